// File: rtl/drum_phase_sweep_pkg.sv
// ============================================================================
// drum_phase_sweep_pkg : shared widths and sweep state encoding for the drum voice
// Rev 1.0
// ============================================================================
`default_nettype none

package drum_phase_sweep_pkg;

   localparam int DPS_PHASE_W     = 32;
   localparam int DPS_ADDR_W      = 8;
   localparam int DPS_LEN_W       = 16;
   localparam int DPS_DECAY_SHIFT = 6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SWEEP   = 2'd1,
      SUSTAIN = 2'd2
   } sweep_state_t;

endpackage

`default_nettype wire

// File: rtl/drum_sweep_step.sv
// ============================================================================
// drum_sweep_step : one exponential decay step of the phase increment toward its end value
// Rev 1.0
// ============================================================================
`default_nettype none

module drum_sweep_step
   import drum_phase_sweep_pkg::*;
#(
   parameter int PHASE_W     = DPS_PHASE_W,
   parameter int DECAY_SHIFT = DPS_DECAY_SHIFT
) (
   input  logic [PHASE_W-1:0] i_inc,
   input  logic [PHASE_W-1:0] i_inc_end,
   output logic [PHASE_W-1:0] o_inc_next,
   output logic               o_converged
);

   logic [PHASE_W-1:0] w_diff;
   logic [PHASE_W-1:0] w_step;

   // i_inc never drops below i_inc_end while sweeping, so the difference is unsigned-safe
   assign w_diff      = i_inc - i_inc_end;
   assign w_step      = w_diff >> DECAY_SHIFT;
   assign o_converged = (w_step == '0);
   assign o_inc_next  = o_converged ? i_inc_end : (i_inc - w_step);

endmodule

`default_nettype wire

// File: rtl/drum_phase_sweep.sv
// ============================================================================
// drum_phase_sweep : pitch-sweeping phase accumulator feeding the sine table address
// Rev 1.0
// ============================================================================
`default_nettype none

module drum_phase_sweep
   import drum_phase_sweep_pkg::*;
#(
   parameter int PHASE_W     = DPS_PHASE_W,
   parameter int ADDR_W      = DPS_ADDR_W,
   parameter int DECAY_SHIFT = DPS_DECAY_SHIFT,
   parameter int LEN_W       = DPS_LEN_W
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               sample_tick,
   input  logic               trig,
   input  logic [PHASE_W-1:0] inc_start,
   input  logic [PHASE_W-1:0] inc_end,
   input  logic [LEN_W-1:0]   note_len,
   output logic [ADDR_W-1:0]  address,
   output logic               addr_valid,
   output logic               sine_valid,
   output logic               busy,
   output logic               done
);

   sweep_state_t       r_state;
   sweep_state_t       w_state_nxt;
   logic [PHASE_W-1:0] r_phase;
   logic [PHASE_W-1:0] r_inc;
   logic [PHASE_W-1:0] r_inc_end;
   logic [PHASE_W-1:0] w_inc_step;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_count;
   logic [LEN_W-1:0]   w_count_inc;
   logic               r_addr_valid;
   logic               r_sine_valid;
   logic               r_done;
   logic               w_converged;
   logic               w_tick;
   logic               w_last;
   logic               w_falling;
   logic               w_len_zero;

   assign w_tick      = sample_tick && !trig && (r_state != IDLE);
   assign w_count_inc = r_count + 1'b1;
   assign w_last      = (w_count_inc == r_len);
   assign w_falling   = (inc_start > inc_end);
   assign w_len_zero  = (note_len == '0);

   drum_sweep_step #(
      .PHASE_W     (PHASE_W),
      .DECAY_SHIFT (DECAY_SHIFT)
   ) u_step (
      .i_inc       (r_inc),
      .i_inc_end   (r_inc_end),
      .o_inc_next  (w_inc_step),
      .o_converged (w_converged)
   );

   always_comb begin
      w_state_nxt = r_state;
      if (trig) begin
         if (w_len_zero)     w_state_nxt = IDLE;
         else if (w_falling) w_state_nxt = SWEEP;
         else                w_state_nxt = SUSTAIN;
      end else if (w_tick) begin
         if (w_last)                                w_state_nxt = IDLE;
         else if (r_state == SWEEP && w_converged)  w_state_nxt = SUSTAIN;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_phase      <= '0;
         r_inc        <= '0;
         r_inc_end    <= '0;
         r_len        <= '0;
         r_count      <= '0;
         r_addr_valid <= 1'b0;
         r_sine_valid <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_addr_valid <= 1'b0;
         r_done       <= 1'b0;
         r_sine_valid <= r_addr_valid;
         if (trig) begin
            r_phase   <= '0;
            r_count   <= '0;
            r_inc_end <= inc_end;
            r_len     <= note_len;
            r_inc     <= w_falling ? inc_start : inc_end;
            r_done    <= w_len_zero;
         end else if (w_tick) begin
            // phase advances by the increment in force before this tick's decay
            r_phase      <= r_phase + r_inc;
            r_count      <= w_count_inc;
            r_addr_valid <= 1'b1;
            r_done       <= w_last;
            if (r_state == SWEEP) r_inc <= w_inc_step;
         end
      end
   end

   assign address    = r_phase[PHASE_W-1 -: ADDR_W];
   assign addr_valid = r_addr_valid;
   assign sine_valid = r_sine_valid;
   assign busy       = (r_state != IDLE);
   assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_drum_phase_sweep.sv
// ============================================================================
// tb_drum_phase_sweep : table-driven notes plus corner sequences, scoreboarded addresses
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_drum_phase_sweep;

   localparam int TB_SHIFT = 1;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sample_tick = 1'b0;
   logic        trig = 1'b0;
   logic [31:0] inc_start = '0;
   logic [31:0] inc_end = '0;
   logic [15:0] note_len = '0;
   logic [7:0]  address;
   logic        addr_valid;
   logic        sine_valid;
   logic        busy;
   logic        done;

   drum_phase_sweep #(
      .PHASE_W     (32),
      .ADDR_W      (8),
      .DECAY_SHIFT (TB_SHIFT),
      .LEN_W       (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sample_tick (sample_tick),
      .trig        (trig),
      .inc_start   (inc_start),
      .inc_end     (inc_end),
      .note_len    (note_len),
      .address     (address),
      .addr_valid  (addr_valid),
      .sine_valid  (sine_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [7:0] addr;
      logic       last;
   } sb_t;

   typedef struct {
      logic [31:0] s;
      logic [31:0] e;
      int          len;
      int          gap;
      logic [7:0]  exp_a0;
      logic [7:0]  exp_a1;
   } vec_t;

   sb_t        sb_q[$];
   logic [7:0] cap_q[$];
   vec_t       vecs[4];
   int         n_tests = 0;
   int         n_fail = 0;
   int         n_done = 0;
   int         d0;

   // reference model of the note engine
   logic [31:0] m_phase, m_inc, m_end, m_diff, m_step;
   int          m_len, m_count;
   bit          m_active = 0, m_sweep = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_trig(input logic [31:0] s, input logic [31:0] e, input int len);
      m_phase  = '0;
      m_count  = 0;
      m_end    = e;
      m_len    = len;
      m_active = (len != 0);
      if (s > e) begin m_inc = s; m_sweep = 1; end
      else       begin m_inc = e; m_sweep = 0; end
   endtask

   task automatic model_tick();
      bit last;
      if (!m_active) return;
      m_phase = m_phase + m_inc;
      m_count++;
      last = (m_count == m_len);
      sb_q.push_back({m_phase[31:24], last});
      if (m_sweep) begin
         m_diff = m_inc - m_end;
         m_step = m_diff >> TB_SHIFT;
         if (m_step == 0) begin m_inc = m_end; m_sweep = 0; end
         else m_inc = m_inc - m_step;
      end
      if (last) m_active = 0;
   endtask

   // all drive tasks start and end 1 time unit after a rising edge
   task automatic do_trig(input logic [31:0] s, input logic [31:0] e, input int len, input logic with_tick);
      trig = 1'b1; inc_start = s; inc_end = e; note_len = 16'(len); sample_tick = with_tick;
      model_trig(s, e, len);
      @(posedge clock); #1;
      trig = 1'b0; sample_tick = 1'b0;
   endtask

   task automatic do_tick();
      sample_tick = 1'b1;
      model_tick();
      @(posedge clock); #1;
      sample_tick = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clock); #1; end
   endtask

   // monitor: pops the scoreboard on every addr_valid, checks sine_valid follows it
   logic prev_av = 1'b0;
   logic rst_s = 1'b1;
   logic exp_sv;
   sb_t  e_item;

   always @(posedge clock) rst_s = reset;

   always @(negedge clock) begin
      exp_sv = prev_av && !rst_s;
      if (sine_valid || exp_sv) check("sine_valid", 32'(sine_valid), 32'(exp_sv));
      if (addr_valid) begin
         if (sb_q.size() == 0) check("spurious_addr_valid", 32'(addr_valid), 32'd0);
         else begin
            e_item = sb_q.pop_front();
            check("address", 32'(address), 32'(e_item.addr));
            check("done_on_last", 32'(done), 32'(e_item.last));
            cap_q.push_back(address);
         end
      end
      if (done) n_done++;
      prev_av = addr_valid;
   end

   initial begin
      vecs[0] = '{s: 32'h0100_0000, e: 32'h0100_0000, len: 4,  gap: 4, exp_a0: 8'h01, exp_a1: 8'h02};
      vecs[1] = '{s: 32'h0200_0000, e: 32'h0100_0000, len: 40, gap: 1, exp_a0: 8'h02, exp_a1: 8'h03};
      vecs[2] = '{s: 32'h8000_0000, e: 32'h8000_0000, len: 4,  gap: 2, exp_a0: 8'h80, exp_a1: 8'h00};
      vecs[3] = '{s: 32'h0040_0000, e: 32'h0300_0000, len: 5,  gap: 3, exp_a0: 8'h03, exp_a1: 8'h06};

      // reset with trig/tick active
      sample_tick = 1'b1;
      @(posedge clock); #1;
      trig = 1'b1; sample_tick = 1'b0; inc_start = 32'h1234_5678; note_len = 16'd3;
      @(posedge clock); #1;
      reset = 1'b0; trig = 1'b0;
      check("rst_address", 32'(address), 32'd0);
      check("rst_addr_valid", 32'(addr_valid), 32'd0);
      check("rst_sine_valid", 32'(sine_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      idle(2);

      for (int i = 0; i < 4; i++) begin
         cap_q.delete();
         d0 = n_done;
         do_trig(vecs[i].s, vecs[i].e, vecs[i].len, 1'b0);
         check("busy_after_trig", 32'(busy), 32'd1);
         for (int k = 0; k < vecs[i].len; k++) begin
            idle(vecs[i].gap - 1);
            do_tick();
         end
         idle(3);
         check("note_busy_end", 32'(busy), 32'd0);
         check("note_sb_empty", 32'(sb_q.size()), 32'd0);
         check("note_done_count", 32'(n_done - d0), 32'd1);
         check("note_addr_count", 32'(cap_q.size()), 32'(vecs[i].len));
         if (cap_q.size() >= 2) begin
            check("note_addr0", 32'(cap_q[0]), 32'(vecs[i].exp_a0));
            check("note_addr1", 32'(cap_q[1]), 32'(vecs[i].exp_a1));
         end
      end

      // note_len == 0: done next cycle, no address, ticks ignored
      d0 = n_done;
      do_trig(32'h0100_0000, 32'h0100_0000, 0, 1'b0);
      check("len0_done", 32'(done), 32'd1);
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_addr_valid", 32'(addr_valid), 32'd0);
      idle(1);
      check("len0_done_width", 32'(done), 32'd0);
      do_tick();
      idle(2);
      check("len0_done_count", 32'(n_done - d0), 32'd1);
      check("len0_sb_empty", 32'(sb_q.size()), 32'd0);

      // retrigger coincident with a tick mid-sweep
      do_trig(32'h0200_0000, 32'h0100_0000, 10, 1'b0);
      repeat (3) do_tick();
      idle(2);
      cap_q.delete();
      d0 = n_done;
      do_trig(32'h0500_0000, 32'h0100_0000, 6, 1'b1);
      check("retrig_tick_dropped", 32'(addr_valid), 32'd0);
      repeat (6) do_tick();
      idle(3);
      do_tick();
      idle(2);
      check("retrig_addr_count", 32'(cap_q.size()), 32'd6);
      if (cap_q.size() >= 1) check("retrig_first_addr", 32'(cap_q[0]), 32'h05);
      check("retrig_done_count", 32'(n_done - d0), 32'd1);
      check("retrig_busy_end", 32'(busy), 32'd0);

      // reset in the middle of a sweep
      d0 = n_done;
      do_trig(32'h0200_0000, 32'h0100_0000, 40, 1'b0);
      repeat (3) do_tick();
      reset = 1'b1; sample_tick = 1'b1; trig = 1'b0;
      m_active = 0;
      @(posedge clock); #1;
      check("midrst_address", 32'(address), 32'd0);
      check("midrst_addr_valid", 32'(addr_valid), 32'd0);
      check("midrst_sine_valid", 32'(sine_valid), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      reset = 1'b0; sample_tick = 1'b0;
      do_tick();
      idle(3);
      check("midrst_sb_empty", 32'(sb_q.size()), 32'd0);
      check("midrst_no_done", 32'(n_done - d0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/drum_phase_sweep.md
# drum_phase_sweep

Phase-accumulator front end for the drum voice. Each sample tick it advances a 32-bit phase by an increment that decays exponentially from a start pitch to an end pitch, giving the classic kick/tom pitch drop. Its top 8 phase bits drive the 8-bit address of the registered sine lookup table directly downstream. It counts out a programmed note length, then returns to idle.

## Interface
Parameters:
- PHASE_W, 32: phase accumulator and increment width.
- ADDR_W, 8: table address width, taken from phase[PHASE_W-1 -: ADDR_W].
- DECAY_SHIFT, 6: increment decay rate; each tick the increment moves 1/2^DECAY_SHIFT of the remaining distance toward inc_end.
- LEN_W, 16: note-length counter width.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- sample_tick  in  1  one-cycle audio-rate strobe.
- trig  in  1  one-cycle note start; latches inc_start, inc_end, note_len.
- inc_start  in  PHASE_W  initial phase increment.
- inc_end  in  PHASE_W  final phase increment.
- note_len  in  LEN_W  number of ticks the note produces.
- address  out  ADDR_W  table address, phase top bits.
- addr_valid  out  1  pulse: address updated this cycle.
- sine_valid  out  1  pulse: table output valid (addr_valid delayed 1 cycle).
- busy  out  1  high in SWEEP or SUSTAIN.
- done  out  1  pulse when a note ends by length.

## Operation
- States: IDLE, SWEEP, SUSTAIN.
- Reset: state IDLE; phase, inc, count, address, addr_valid, sine_valid, busy, done all 0.
- trig (any state, including mid-note): phase<=0, count<=0, inc<=inc_start, end/len latched. Next state SWEEP if inc_start>inc_end, else SUSTAIN with inc<=inc_end. If note_len==0: next state IDLE, done pulses next cycle, no addr_valid.
- trig and sample_tick in same cycle: trig wins, tick discarded.
- sample_tick in SWEEP/SUSTAIN: phase<=phase+inc (old inc, modulo 2^PHASE_W); count<=count+1; addr_valid pulses.
- Decay in SWEEP on each tick: diff=inc-inc_end (invariant inc>=inc_end, unsigned); step=diff>>DECAY_SHIFT; step==0 -> inc<=inc_end, go SUSTAIN; else inc<=inc-step.
- SUSTAIN: inc constant.
- On the tick where count+1==note_len: state->IDLE, done pulses together with that final addr_valid.
- sample_tick in IDLE: ignored. Phase and address hold their last value in IDLE.
- reset mid-note overrides trig and tick.

## Timing
- Tick sampled at cycle t -> address and addr_valid at t+1; downstream table registers at t+1 edge, sine_valid at t+2.
- trig at t -> busy at t+1; first tick accepted from t+1.
- address is the registered phase's top bits (no extra latency).
- done, addr_valid, sine_valid each exactly one cycle wide.
- Back-to-back ticks (every cycle) supported at full rate.

## Structure
- Shared package: PHASE_W/ADDR_W/LEN_W defaults and the state enum (IDLE, SWEEP, SUSTAIN), reused by the later envelope stage.
- One sub-module natural: drum_sweep_step, combinational diff/shift/compare producing next inc and the converged flag.
- Top holds FSM, phase register, counter, valid pipeline.

## Test plan
- Reset: assert reset 2 cycles with trig/tick toggling -> all outputs 0, busy 0.
- Constant pitch: inc_start=inc_end=0x0100_0000, note_len=4, tick every 4 cycles -> address 0x01,0x02,0x03,0x04; four addr_valid; sine_valid 1 cycle after each; done with 4th; busy 0 after.
- Sweep: inc_start=0x0200_0000, inc_end=0x0100_0000, DECAY_SHIFT=1, note_len=40 -> addresses 0x02,0x03 (inc 0x0180_0000, 0x0140_0000); SUSTAIN entered on tick 25 with inc==0x0100_0000.
- Wrap: inc=0x8000_0000 constant -> address alternates 0x80,0x00.
- Retrigger: trig coincident with tick mid-sweep -> tick ignored, next tick address==inc_start[31:24], count restarts, full note_len ticks follow.
- Edge: note_len=0 -> done next cycle, no addr_valid; reset mid-SWEEP -> IDLE, outputs 0 next cycle.
